// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with branch redirect and decode handshake
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_branch_en,
  input  logic [15:0] i_branch_target
);
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
  state_t      r_state, w_state;
  logic [15:0] r_fetch_pc, w_fetch_pc;
  logic [15:0] r_pend_pc, w_pend_pc;
  logic [15:0] r_instr, w_instr;
  logic [15:0] r_instr_pc, w_instr_pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= 16'h0000;
      r_instr    <= 16'h0000;
      r_instr_pc <= 16'h0000;
    end else begin
      r_state    <= w_state;
      r_fetch_pc <= w_fetch_pc;
      r_pend_pc  <= w_pend_pc;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
    end
  end
  // DRAIN keeps the bus request up until the stale ack arrives, then jumps to the pending target
  always_comb begin
    w_state    = r_state;
    w_fetch_pc = r_fetch_pc;
    w_pend_pc  = r_pend_pc;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    case (r_state)
      FETCH: begin
        if (i_mem_ack && i_branch_en) begin
          w_fetch_pc = i_branch_target;
        end else if (i_mem_ack) begin
          w_instr    = i_mem_rdata;
          w_instr_pc = r_fetch_pc;
          w_fetch_pc = r_fetch_pc + 16'd1;
          w_state    = HOLD;
        end else if (i_branch_en) begin
          w_pend_pc = i_branch_target;
          w_state   = DRAIN;
        end
      end
      DRAIN: begin
        if (i_mem_ack) begin
          w_fetch_pc = i_branch_en ? i_branch_target : r_pend_pc;
          w_state    = FETCH;
        end else if (i_branch_en) begin
          w_pend_pc = i_branch_target;
        end
      end
      HOLD: begin
        if (i_branch_en) begin
          w_fetch_pc = i_branch_target;
          w_state    = FETCH;
        end else if (i_instr_ready) begin
          w_state = FETCH;
        end
      end
      default: w_state = FETCH;
    endcase
  end
  assign o_mem_req     = (r_state != HOLD);
  assign o_mem_addr    = r_fetch_pc;
  assign o_instr_valid = (r_state == HOLD);
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a transaction-level fetch model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        i_branch_en;
  logic [15:0] i_branch_target;
  int total = 0;
  int bad = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready),
    .i_branch_en(i_branch_en), .i_branch_target(i_branch_target)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_ack = 0; i_mem_rdata = 0; i_instr_ready = 0; i_branch_en = 0; i_branch_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    step();
    i_mem_ack = 1; i_mem_rdata = 16'h1234;
    #2 rst_n = 0;
    #1;
    total++; if (o_mem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", o_mem_req); end
    total++; if (o_mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", o_mem_addr); end
    total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_instr_valid); end
    total++; if (o_instr !== 16'h0000 || o_instr_pc !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h/%h exp=0000/0000", o_instr, o_instr_pc); end
    step();
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_ack_ignored got=%b/%h exp=0/0000", o_instr_valid, o_mem_addr); end
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_stream();
    do_reset();
    i_mem_ack = 1; i_instr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i_mem_rdata = o_mem_addr ^ 16'hA5A5;
      total++; if (o_mem_req !== 1'b1 || o_mem_addr !== k[15:0]) begin bad++; $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, o_mem_req, o_mem_addr, k[15:0]); end
      step();
      total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== k[15:0] || o_instr !== (k[15:0] ^ 16'hA5A5)) begin
        bad++; $display("FAIL stream_instr k=%0d got=%b/%h/%h exp=1/%h/%h", k, o_instr_valid, o_instr_pc, o_instr, k[15:0], k[15:0] ^ 16'hA5A5);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_branch_wait();
    do_reset();
    i_mem_ack = 1; i_branch_en = 1; i_branch_target = 16'h0005;
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0005 || o_instr_valid !== 1'b0) begin bad++; $display("FAIL bwait_hold c=%0d got=%b/%h/%b exp=1/0005/0", c, o_mem_req, o_mem_addr, o_instr_valid); end
      i_branch_en = (c == 1); i_branch_target = 16'h0100;
      step();
      i_branch_en = 0;
    end
    i_mem_ack = 1; i_mem_rdata = 16'hDEAD;
    total++; if (o_mem_addr !== 16'h0005) begin bad++; $display("FAIL bwait_ackcycle got=%h exp=0005", o_mem_addr); end
    step();
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'h0100) begin bad++; $display("FAIL bwait_redirect got=%b/%h exp=0/0100", o_instr_valid, o_mem_addr); end
    i_mem_rdata = 16'h4242;
    step();
    total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0100 || o_instr !== 16'h4242) begin bad++; $display("FAIL bwait_instr got=%b/%h/%h exp=1/0100/4242", o_instr_valid, o_instr_pc, o_instr); end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    i_mem_ack = 1; i_mem_rdata = 16'h7777;
    step();
    i_mem_rdata = 16'h1111;
    for (int c = 0; c < 4; c++) begin
      total++; if (o_instr_valid !== 1'b1 || o_mem_req !== 1'b0 || o_instr !== 16'h7777 || o_instr_pc !== 16'h0000) begin
        bad++; $display("FAIL stall c=%0d got=%b/%b/%h/%h exp=1/0/7777/0000", c, o_instr_valid, o_mem_req, o_instr, o_instr_pc);
      end
      step();
    end
    i_instr_ready = 1; i_mem_ack = 0;
    step();
    total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0001 || o_instr_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b/%h/%b exp=1/0001/0", o_mem_req, o_mem_addr, o_instr_valid); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    i_mem_ack = 1; i_mem_rdata = 16'h0BAD;
    step();
    i_mem_ack = 0; i_instr_ready = 1; i_branch_en = 1; i_branch_target = 16'hFFFF;
    step();
    i_branch_en = 0;
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_branch got=%b/%h exp=0/ffff", o_instr_valid, o_mem_addr); end
    i_mem_ack = 1; i_mem_rdata = 16'h1234;
    step();
    i_mem_ack = 0;
    total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'hFFFF || o_instr !== 16'h1234) begin bad++; $display("FAIL wrap_instr got=%b/%h/%h exp=1/ffff/1234", o_instr_valid, o_instr_pc, o_instr); end
    step();
    total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/0000", o_mem_req, o_mem_addr); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    i_mem_ack = 1; i_branch_en = 1; i_branch_target = 16'h0050;
    step();
    i_mem_ack = 0; i_branch_target = 16'h0300;
    step();
    i_branch_en = 0;
    total++; if (o_mem_addr !== 16'h0050) begin bad++; $display("FAIL areset_drain_addr got=%h exp=0050", o_mem_addr); end
    #2 rst_n = 0;
    #1;
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'h0000 || o_mem_req !== 1'b1) begin bad++; $display("FAIL areset_drain got=%b/%h/%b exp=0/0000/1", o_instr_valid, o_mem_addr, o_mem_req); end
    step();
    rst_n = 1;
    i_mem_ack = 1; i_mem_rdata = 16'h5A5A;
    step();
    total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000 || o_instr !== 16'h5A5A) begin bad++; $display("FAIL areset_after got=%b/%h/%h exp=1/0000/5a5a", o_instr_valid, o_instr_pc, o_instr); end
    i_mem_ack = 0;
    #2 rst_n = 0;
    #1;
    total++; if (o_instr_valid !== 1'b0 || o_instr !== 16'h0000) begin bad++; $display("FAIL areset_hold got=%b/%h exp=0/0000", o_instr_valid, o_instr); end
    step();
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    i_mem_ack = 1; i_mem_rdata = 16'hEEEE; i_branch_en = 1; i_branch_target = 16'h0200;
    step();
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'h0200) begin bad++; $display("FAIL same_fetch got=%b/%h exp=0/0200", o_instr_valid, o_mem_addr); end
    i_mem_ack = 0; i_branch_target = 16'h0400;
    step();
    i_mem_ack = 1; i_branch_target = 16'h0600;
    step();
    total++; if (o_instr_valid !== 1'b0 || o_mem_addr !== 16'h0600) begin bad++; $display("FAIL same_drain got=%b/%h exp=0/0600", o_instr_valid, o_mem_addr); end
    i_branch_en = 0; i_mem_rdata = 16'h0F0F;
    step();
    total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0600 || o_instr !== 16'h0F0F) begin bad++; $display("FAIL same_instr got=%b/%h/%h exp=1/0600/0f0f", o_instr_valid, o_instr_pc, o_instr); end
    idle_inputs();
  endtask

  // model: one request in flight; any branch seen while it is in flight spoils its data
  task automatic test_random();
    logic [15:0] m_pc, m_tgt, m_instr, m_ipc;
    logic        m_redir, m_hold;
    do_reset();
    m_pc = 16'h0000; m_tgt = 0; m_instr = 0; m_ipc = 0; m_redir = 0; m_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      i_mem_ack       = 1'($urandom_range(0, 1));
      i_branch_en     = ($urandom_range(0, 6) == 0);
      i_instr_ready   = ($urandom_range(0, 2) != 0);
      i_mem_rdata     = 16'($urandom);
      i_branch_target = (n % 97 == 5) ? 16'hFFFF : 16'($urandom);
      total++; if (o_mem_req !== ~m_hold || o_instr_valid !== m_hold) begin bad++; $display("FAIL rand_ctl n=%0d got=%b/%b exp=%b/%b", n, o_mem_req, o_instr_valid, ~m_hold, m_hold); end
      if (!m_hold) begin
        total++; if (o_mem_addr !== m_pc) begin bad++; $display("FAIL rand_addr n=%0d got=%h exp=%h", n, o_mem_addr, m_pc); end
      end else begin
        total++; if (o_instr !== m_instr || o_instr_pc !== m_ipc) begin bad++; $display("FAIL rand_instr n=%0d got=%h/%h exp=%h/%h", n, o_instr, o_instr_pc, m_instr, m_ipc); end
      end
      if (m_hold) begin
        if (i_branch_en) begin m_pc = i_branch_target; m_hold = 0; end
        else if (i_instr_ready) m_hold = 0;
      end else begin
        if (i_branch_en) begin m_redir = 1; m_tgt = i_branch_target; end
        if (i_mem_ack) begin
          if (m_redir) begin m_pc = m_tgt; m_redir = 0; end
          else begin m_hold = 1; m_instr = i_mem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd1; end
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch_wait();
    test_stall();
    test_wrap();
    test_async_reset();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: mem_req  output  1  instruction memory read request.
REQ-005 Port: mem_addr  output  16  word address of current request.
REQ-006 Port: mem_ack  input  1  memory returns mem_rdata this cycle; sampled only while mem_req=1.
REQ-007 Port: mem_rdata  input  16  instruction word, valid when mem_ack=1.
REQ-008 Port: instr  output  16  held instruction to decode stage.
REQ-009 Port: instr_pc  output  16  address from which instr was fetched.
REQ-010 Port: instr_valid  output  1  instr/instr_pc valid.
REQ-011 Port: instr_ready  input  1  decode stage accepts instr when instr_valid=1.
REQ-012 Port: branch_en  input  1  redirect fetch; single-cycle pulse.
REQ-013 Port: branch_target  input  16  redirect address, valid with branch_en.

Function
REQ-014 FSM states SHALL be FETCH, DRAIN, HOLD; internal regs fetch_pc[15:0], pend_pc[15:0].
REQ-015 FETCH: mem_req=1, mem_addr=fetch_pc, instr_valid=0.
REQ-016 DRAIN: mem_req=1, mem_addr=fetch_pc (unchanged), instr_valid=0; returned data discarded.
REQ-017 HOLD: mem_req=0, instr_valid=1; instr/instr_pc stable until leaving HOLD.
REQ-018 mem_addr SHALL NOT change while mem_req=1 and mem_ack=0.
REQ-019 FETCH, ack=1, branch_en=0: instr<=mem_rdata, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+1, -> HOLD.
REQ-020 FETCH, ack=1, branch_en=1: data discarded, fetch_pc<=branch_target, stay FETCH.
REQ-021 FETCH, ack=0, branch_en=1: pend_pc<=branch_target, -> DRAIN.
REQ-022 FETCH, ack=0, branch_en=0: hold state and all registers.
REQ-023 DRAIN, ack=1: fetch_pc<=(branch_en ? branch_target : pend_pc), -> FETCH.
REQ-024 DRAIN, ack=0, branch_en=1: pend_pc<=branch_target (latest branch wins), stay DRAIN.
REQ-025 HOLD, branch_en=1: fetch_pc<=branch_target, -> FETCH; branch has priority over instr_ready; held instr dropped.
REQ-026 HOLD, branch_en=0, instr_ready=1: handshake completes, -> FETCH (fetch_pc already incremented).
REQ-027 HOLD, branch_en=0, instr_ready=0: hold everything.
REQ-028 Latency: ack in cycle N -> instr_valid=1 in N+1; handshake at edge N -> mem_req=1 in N+1 with next address.
REQ-029 fetch_pc increment SHALL wrap 16'hFFFF -> 16'h0000; no flag.
REQ-030 At most one outstanding request; no new address issued before ack of the current one.

Reset
REQ-031 reset=0 SHALL immediately (no clock) force state=FETCH, fetch_pc=RESET_PC, pend_pc=0, instr=0, instr_pc=0, instr_valid=0.
REQ-032 During reset: mem_req=1, mem_addr=RESET_PC; mem_ack ignored while reset=0.
REQ-033 Reset mid-request or in DRAIN/HOLD SHALL abandon all in-flight data; first post-reset fetch is RESET_PC.
REQ-034 Reset deassertion SHALL be sampled synchronously; first state change on the first rising edge with reset=1.

Verification
REQ-035 Reset release, mem_ack=1 every req cycle, instr_ready=1, mem_rdata=addr^16'hA5A5 -> instr_pc sequence 0,1,2,3; instr=16'hA5A5,16'hA5A4,...; one instr per 2 cycles.
REQ-036 Ack delayed 3 cycles at addr 5, branch_en=1 target 16'h0100 in 2nd wait cycle -> mem_addr stays 5 until ack, data discarded, next mem_addr=16'h0100, next instr_pc=16'h0100.
REQ-037 HOLD with instr_ready=0 for 4 cycles -> instr/instr_valid stable, mem_req=0; then ready=1 -> next mem_addr=instr_pc+1.
REQ-038 branch_en=1 target 16'hFFFF in HOLD with instr_ready=1 -> held instr not counted, fetches 16'hFFFF then 16'h0000 (wrap).
REQ-039 reset=0 asynchronously mid-DRAIN (between edges) -> instr_valid=0 and mem_addr=RESET_PC before next edge; no pending target used afterwards.
REQ-040 ack and branch_en same cycle in FETCH and in DRAIN -> data discarded, next mem_addr=branch_target, instr_valid stays 0.
